// File: rtl/card_deck_shuffler.sv
// rtl/card_deck_shuffler.sv - LFSR Fisher-Yates deck shuffler streaming pairs into the card regfile
module card_deck_shuffler #(
  parameter int          MAX_CARDS = 12,
  parameter int          ADDR_W    = 5,
  parameter int          BASE_ADDR = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        num_cards,
  input  logic              shuffle_en,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [13:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, SHUFFLE, WRITE} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [4:0]  n;
  logic [3:0]  i;
  logic [3:0]  j;
  logic [3:0]  j_nxt;
  logic [3:0]  mask;
  logic [3:0]  r;
  logic        fb;
  logic        start_ok;
  logic [2:0]  deck [MAX_CARDS];

  function automatic logic [11:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 12'hF00;
      3'd1:    palette = 12'h0F0;
      3'd2:    palette = 12'h00F;
      3'd3:    palette = 12'h0FF;
      3'd4:    palette = 12'hF0F;
      3'd5:    palette = 12'hFF0;
      3'd6:    palette = 12'h0AA;
      default: palette = 12'hFFF;
    endcase
  endfunction

  assign fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign j_nxt = j + 4'd1;

  always_comb begin
    mask = 4'd1;
    if (i >= 4'd8)      mask = 4'd15;
    else if (i >= 4'd4) mask = 4'd7;
    else if (i >= 4'd2) mask = 4'd3;
    r        = lfsr[3:0] & mask;
    start_ok = !num_cards[0] && (num_cards >= 5'd2) && (num_cards <= 5'(MAX_CARDS));
  end

  // Deck storage carries no reset; its contents are rebuilt on every accepted start.
  always_ff @(posedge clk) begin
    if (state == IDLE && start && start_ok) begin
      for (int k = 0; k < MAX_CARDS; k++) deck[k] <= 3'(k >> 1);
    end else if (state == SHUFFLE && r <= i) begin
      deck[i] <= deck[r];
      deck[r] <= deck[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= LFSR_SEED;
      n       <= 5'd0;
      i       <= 4'd0;
      j       <= 4'd0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 14'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], fb};
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              n    <= num_cards;
              busy <= 1'b1;
              if (shuffle_en) begin
                state <= SHUFFLE;
                i     <= 4'(num_cards - 5'd1);
              end else begin
                state   <= WRITE;
                j       <= 4'd0;
                wr_en   <= 1'b1;
                wr_addr <= ADDR_W'(BASE_ADDR);
                wr_data <= {palette(3'd0), 2'b01};
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        SHUFFLE: begin
          if (r <= i) begin
            i <= i - 4'd1;
            // Final draw (i == 1) may swap into slot 0, so forward the post-swap value.
            if (i == 4'd1) begin
              state   <= WRITE;
              j       <= 4'd0;
              wr_en   <= 1'b1;
              wr_addr <= ADDR_W'(BASE_ADDR);
              wr_data <= {palette((r == 4'd0) ? deck[1] : deck[0]), 2'b01};
            end
          end
        end
        WRITE: begin
          if (wr_ready) begin
            if ({1'b0, j} == n - 5'd1) begin
              wr_en <= 1'b0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              j       <= j_nxt;
              wr_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(j_nxt);
              wr_data <= {palette(deck[j_nxt]), 2'b01};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_deck_shuffler.sv
// tb/tb_card_deck_shuffler.sv - directed self-checking bench for card_deck_shuffler
module tb_card_deck_shuffler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  num_cards;
  logic        shuffle_en;
  logic        wr_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [13:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [13:0] exp_det [12];
  logic [11:0] pal [6];
  logic [13:0] first_run [12];
  logic        have_first;
  logic        orders_differ;

  always #5 clk = ~clk;

  card_deck_shuffler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_cards(num_cards),
    .shuffle_en(shuffle_en), .wr_ready(wr_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; num_cards = 5'd0; shuffle_en = 1'b0; wr_ready = 1'b1;
    #3;
    checks++;
    if ({wr_en, busy, done, err} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0000", {wr_en, busy, done, err});
    end
    checks++;
    if (wr_addr !== 5'd0 || wr_data !== 14'd0) begin
      failures++; $display("FAIL reset_bus got=%h/%h exp=00/0000", wr_addr, wr_data);
    end
    tick;
    checks++;
    if (dut.lfsr !== 16'hACE1) begin
      failures++; $display("FAIL reset_lfsr got=%h exp=ace1", dut.lfsr);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_deterministic;
    num_cards = 5'd12; shuffle_en = 1'b0; wr_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(c) || wr_data !== exp_det[c-1] || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL det_write c=%0d got en=%b addr=%0d data=%h busy=%b done=%b exp en=1 addr=%0d data=%h busy=1 done=0",
                 c, wr_en, wr_addr, wr_data, busy, done, c, exp_det[c-1]);
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
      failures++; $display("FAIL det_done got done=%b busy=%b en=%b exp 1 0 0", done, busy, wr_en);
    end
    tick;
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL det_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic shuffle_run(input int delay);
    logic [13:0] datas [12];
    int hist [6];
    int nw;
    int bad_addr;
    for (int d = 0; d < delay; d++) tick;
    num_cards = 5'd12; shuffle_en = 1'b1; wr_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    nw = 0; bad_addr = 0;
    for (int p = 0; p < 6; p++) hist[p] = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (wr_en && wr_ready) begin
        if (nw < 12) begin
          datas[nw] = wr_data;
          if (wr_addr !== 5'(nw + 1)) bad_addr++;
        end
        nw++;
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || nw != 12) begin
      failures++; $display("FAIL shuf_count delay=%0d got writes=%0d done=%b exp writes=12 done=1", delay, nw, done);
    end
    checks++;
    if (bad_addr != 0) begin
      failures++; $display("FAIL shuf_addr delay=%0d got bad=%0d exp=0", delay, bad_addr);
    end
    for (int w = 0; w < 12 && w < nw; w++)
      for (int p = 0; p < 6; p++)
        if (datas[w] == {pal[p], 2'b01}) hist[p]++;
    for (int p = 0; p < 6; p++) begin
      checks++;
      if (hist[p] != 2) begin
        failures++; $display("FAIL shuf_colour delay=%0d colour=%h got=%0d exp=2", delay, pal[p], hist[p]);
      end
    end
    if (nw == 12) begin
      if (!have_first) begin
        for (int w = 0; w < 12; w++) first_run[w] = datas[w];
        have_first = 1'b1;
      end else begin
        for (int w = 0; w < 12; w++) if (datas[w] !== first_run[w]) orders_differ = 1'b1;
      end
    end
    tick;
  endtask

  task automatic test_shuffle;
    have_first = 1'b0; orders_differ = 1'b0;
    shuffle_run(0);
    shuffle_run(3);
    shuffle_run(7);
    checks++;
    if (orders_differ !== 1'b1) begin
      failures++; $display("FAIL shuf_orders_differ got=%b exp=1", orders_differ);
    end
  endtask

  task automatic test_backpressure;
    logic        rdy [7]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0]  ea  [7]   = '{5'd1, 5'd2, 5'd2, 5'd2, 5'd3, 5'd3, 5'd4};
    logic [13:0] ed  [7]   = '{14'h3C01, 14'h3C01, 14'h3C01, 14'h3C01, 14'h03C1, 14'h03C1, 14'h03C1};
    int acc;
    num_cards = 5'd4; shuffle_en = 1'b0; wr_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    acc = 0;
    for (int c = 0; c < 7; c++) begin
      wr_ready = rdy[c];
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== ea[c] || wr_data !== ed[c]) begin
        failures++;
        $display("FAIL bp_hold c=%0d got en=%b addr=%0d data=%h exp en=1 addr=%0d data=%h",
                 c + 1, wr_en, wr_addr, wr_data, ea[c], ed[c]);
      end
      if (wr_en && wr_ready) acc++;
      tick;
    end
    wr_ready = 1'b1;
    checks++;
    if (acc != 4 || done !== 1'b1 || wr_en !== 1'b0) begin
      failures++; $display("FAIL bp_done got acc=%0d done=%b en=%b exp acc=4 done=1 en=0", acc, done, wr_en);
    end
    tick;
  endtask

  task automatic test_invalid;
    logic [4:0] bad [3] = '{5'd7, 5'd0, 5'd14};
    for (int t = 0; t < 3; t++) begin
      num_cards = bad[t]; shuffle_en = 1'b0; wr_ready = 1'b1; start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL inv_err n=%0d got err=%b en=%b busy=%b exp 1 0 0", bad[t], err, wr_en, busy);
      end
      tick;
      checks++;
      if (err !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL inv_pulse n=%0d got err=%b en=%b busy=%b exp 0 0 0", bad[t], err, wr_en, busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    int nw;
    int nd;
    int bad_addr;
    num_cards = 5'd12; shuffle_en = 1'b0; wr_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    num_cards = 5'd4; start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd3 || err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL b2b_ignore got en=%b addr=%0d err=%b busy=%b exp 1 3 0 1", wr_en, wr_addr, err, busy);
    end
    tick;
    tick;
    checks++;
    if (wr_addr !== 5'd5) begin
      failures++; $display("FAIL b2b_at_write5 got=%0d exp=5", wr_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, busy, done, err} !== 4'b0000) begin
      failures++; $display("FAIL midrst_outputs got=%b exp=0000", {wr_en, busy, done, err});
    end
    tick;
    checks++;
    if (dut.lfsr !== 16'hACE1 || done !== 1'b0) begin
      failures++; $display("FAIL midrst_lfsr got=%h done=%b exp=ace1 done=0", dut.lfsr, done);
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
      failures++; $display("FAIL midrst_quiet got done=%b busy=%b en=%b exp 0 0 0", done, busy, wr_en);
    end
    num_cards = 5'd12; start = 1'b1;
    tick;
    start = 1'b0;
    nw = 0; nd = 0; bad_addr = 0;
    for (int c = 0; c < 40; c++) begin
      if (wr_en && wr_ready) begin
        if (wr_addr !== 5'(nw + 1)) bad_addr++;
        nw++;
      end
      if (done) nd++;
      tick;
    end
    checks++;
    if (nw != 12 || nd != 1 || bad_addr != 0) begin
      failures++; $display("FAIL restart_run got writes=%0d dones=%0d bad_addr=%0d exp 12 1 0", nw, nd, bad_addr);
    end
  endtask

  initial begin
    exp_det = '{14'h3C01, 14'h3C01, 14'h03C1, 14'h03C1, 14'h003D, 14'h003D,
                14'h03FD, 14'h03FD, 14'h3C3D, 14'h3C3D, 14'h3FC1, 14'h3FC1};
    pal     = '{12'hF00, 12'h0F0, 12'h00F, 12'h0FF, 12'hF0F, 12'hFF0};
    test_reset;
    test_deterministic;
    test_shuffle;
    test_backpressure;
    test_invalid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
